// File: rtl/sram_pkg.sv
// Shared definitions for the asynchronous-style SRAM target: FSM states,
// read-latency limits, byte-lane indices and small decode helpers.
// Latency: n/a (types and constants only). Backpressure: n/a.
package sram_pkg;

  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 16;
  localparam int NUM_LANES = 2;
  localparam int LANE_W    = 8;

  // Lane indices into per-lane vectors; lane LANE_HI is data[15:8].
  localparam int LANE_LO = 0;
  localparam int LANE_HI = 1;

  // Supported read latency range, in clock edges from capture to drive.
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 3;

  // Wide enough to hold READ_LAT_MAX-1.
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_WAIT  = 2'd1,
    ST_READ_DRIVE = 2'd2
  } sram_state_e;

  // Active-high lane enables from the active-low byte masks.
  function automatic logic [NUM_LANES-1:0] lane_en(input logic hb_n, input logic lb_n);
    lane_en          = '0;
    lane_en[LANE_HI] = !hb_n;
    lane_en[LANE_LO] = !lb_n;
  endfunction

  // True when the halfword address lies inside the implemented array.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a, input int depth_log2);
    addr_in_range = ((32'(a) >> depth_log2) == 32'd0);
  endfunction

endpackage

// File: rtl/sram_lane_mem.sv
// Byte-lane split storage array with per-lane write enables and a registered read port.
// Latency: write lands on the sampling edge; read data is registered one edge after re_i.
// Backpressure: none; every enabled access completes on its edge.
// Ports: clk_i; waddr_i/we_i/wdata_i write port; re_i/raddr_i/rzero_i/rdata_o read port.
module sram_lane_mem
  import sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [NUM_LANES-1:0]  we_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  input  logic                  rzero_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    // Contents are intentionally not reset so they survive a reset pulse.
    logic [LANE_W-1:0] mem_q [DEPTH];
    logic [LANE_W-1:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (we_i[l]) begin
        mem_q[waddr_i] <= wdata_i[l*LANE_W +: LANE_W];
      end
      if (re_i) begin
        // Out-of-range reads alias onto a real row; force them to zero here.
        rd_q <= rzero_i ? '0 : mem_q[raddr_i];
      end
    end

    assign rdata_o[l*LANE_W +: LANE_W] = rd_q;
  end

endmodule

// File: rtl/sram_target.sv
// SRAM-style target: async-SRAM pin protocol sampled on a clock, byte lanes, tristate bus.
// Latency: writes complete on the sampling edge; read data drives READ_LAT edges after capture.
// Backpressure: none; an address change during a read restarts the latency count.
// Ports: clock, reset (async active-low), addr[17:0], data[15:0] inout,
//        wre/oute/chip_en/hb_mask/lb_mask (all active-low), err (sticky error flag).
// Build option: define SRAM_TARGET_ERRFLAG_EN to implement err; otherwise err is tied low.
module sram_target
  import sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int READ_LAT   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  input  logic              wre,
  input  logic              oute,
  input  logic              chip_en,
  input  logic              hb_mask,
  input  logic              lb_mask,
  output logic              err
);

  localparam int LAT = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                       (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  sram_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 mem_re;

  logic                 wr_dec, rd_dec, in_range, drive_en;
  logic [NUM_LANES-1:0] lane_on;
  logic [DATA_W-1:0]    rdata;

  // Write wins over read when wre and oute are both low.
  assign wr_dec   = !chip_en && !wre;
  assign rd_dec   = !chip_en && wre && !oute;
  assign in_range = addr_in_range(addr, DEPTH_LOG2);
  assign lane_on  = lane_en(hb_mask, lb_mask);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    mem_re  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_dec) begin
          state_d = ST_READ_WAIT;
          cnt_d   = CNT_LOAD;
          addr_d  = addr;
        end
      end
      ST_READ_WAIT: begin
        if (!rd_dec) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (addr != addr_q) begin
          cnt_d  = CNT_LOAD;
          addr_d = addr;
        end else if (cnt_q == '0) begin
          // Array read is registered on the same edge that enters the drive state.
          state_d = ST_READ_DRIVE;
          mem_re  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_READ_DRIVE: begin
        if (!rd_dec) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (addr != addr_q) begin
          state_d = ST_READ_WAIT;
          cnt_d   = CNT_LOAD;
          addr_d  = addr;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  sram_lane_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk_i   (clock),
    .waddr_i (addr[DEPTH_LOG2-1:0]),
    .we_i    ((wr_dec && in_range) ? lane_on : '0),
    .wdata_i (data),
    .re_i    (mem_re),
    .raddr_i (addr_q[DEPTH_LOG2-1:0]),
    .rzero_i (!addr_in_range(addr_q, DEPTH_LOG2)),
    .rdata_o (rdata)
  );

  // Pin qualifiers are used live so the bus releases without waiting for an edge.
  assign drive_en = (state_q == ST_READ_DRIVE) && rd_dec;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_drv
    assign data[l*LANE_W +: LANE_W] = (drive_en && lane_on[l]) ? rdata[l*LANE_W +: LANE_W]
                                                                : {LANE_W{1'bz}};
  end

`ifdef SRAM_TARGET_ERRFLAG_EN
  logic err_q, err_d;

  assign err_d = err_q || (!chip_en && (!in_range || (!wre && !oute)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
